status_checker: RTL and testbench
=================================

// Module: status_checker
// PURPOSE
// - Receiving end of the core status interface (o_status/o_status_valid): consumes each per-instruction status beat.
// - Fetches the expected status for each beat from a golden status ROM and compares; counts beats and mismatches.
// - Declares pass/fail when a terminal status arrives. Sits beside the core and the memories at testbed/top level.
// PARAMETERS
// - GOLD_AW    8    golden ROM address width; max beats checked = 2**GOLD_AW
// - CNT_W      16   width of beat and error counters
// - WDOG_CYC   120000 watchdog limit in cycles (used only with STATUS_WDOG_EN)
// PORTS
// - i_clk            in   1        single clock, rising edge
// - i_rst_n          in   1        asynchronous, active-low reset
// - i_status         in   2        status code from core
// - i_status_valid   in   1        one-cycle qualifier for i_status
// - o_g_addr         out  GOLD_AW  golden ROM index = current beat number
// - i_g_status       in   2        golden status at o_g_addr, combinational read, same cycle
// - o_done           out  1        check finished (sticky until reset)
// - o_pass           out  1        valid with o_done: 1 = zero mismatches, no protocol error
// - o_err_cnt        out  CNT_W    mismatch count (saturating)
// - o_beat_cnt       out  CNT_W    accepted beats (saturating)
// - o_first_err      out  GOLD_AW  beat index of first mismatch; 0 if none
// - o_proto_err      out  1        sticky: beat after done, or beat index overflow
// BEHAVIOUR
// - Status codes (shared pkg): R_TYPE=2'd0, I_TYPE=2'd1, MIPS_OVERFLOW=2'd2, MIPS_END=2'd3; 2 and 3 are terminal.
// - Reset: all outputs 0, FSM=RUN, o_g_addr=0. Async assert, sync-safe deassert via flop reset only.
// - FSM: RUN -> DONE on accepted beat where i_status OR i_g_status is terminal; RUN -> DONE on index overflow.
//   DONE is absorbing until reset.
// - Accept: in RUN, i_status_valid=1 accepts a beat that cycle; no backpressure, every valid beat is consumed.
// - Compare: mismatch when i_status != i_g_status in accept cycle; o_err_cnt++ (saturate at all-ones);
//   first mismatch captures o_first_err = o_g_addr (later mismatches do not overwrite).
// - o_g_addr increments by 1 each accepted beat, registered; counters/flags update 1 cycle after the accept edge.
// - o_done rises the cycle after the terminating beat; o_pass = (err_cnt==0)&&!proto_err, computed from final-beat
//   results (the terminating beat's compare is included).
// - Golden terminal but DUT non-terminal: counted mismatch, done. DUT terminal early: mismatch, done.
// - Overflow: accept at o_g_addr = 2**GOLD_AW-1 without terminal -> o_proto_err=1, done, o_pass=0; no wrap.
// - i_status_valid in DONE: beat ignored, o_proto_err=1 (o_pass drops to 0 next cycle).
// - Reset mid-run: all state cleared immediately; run restarts at beat 0.
// CONFIGURATION
// - STATUS_WDOG_EN defined: cycle counter runs in RUN, cleared on each accepted beat; reaching WDOG_CYC
//   idle cycles forces DONE with o_proto_err=1, o_pass=0.
// - STATUS_WDOG_EN undefined: no watchdog logic; RUN may persist indefinitely; WDOG_CYC unused.
// STRUCTURE
// - Package status_pkg: status code localparams, terminal-test function, FSM state enum {S_RUN,S_DONE}.
// - One sub-module: sat_counter (parametric width, inc, clear, saturate) for beat/error/watchdog counters.
// - Compare, first-error capture and FSM stay in status_checker.
// TESTING
// - Golden {0,1,0,3}, DUT same 4 beats back-to-back -> o_done cycle after beat 3, o_pass=1, err=0, beat_cnt=4.
// - Golden {0,1,3}, DUT {0,0,3} with gaps -> err=1, o_first_err=1, o_pass=0, done after beat 2.
// - Golden {0,0,0,3}, DUT {0,2} -> done after beat 1, err=1, o_first_err=1, beat_cnt=2.
// - After pass, extra i_status_valid -> o_proto_err=1, o_pass=0, counters unchanged.
// - GOLD_AW=2, golden all 0, DUT 4 beats of 0 -> overflow at beat 3: o_proto_err=1, done, o_g_addr stays 3.
// - Reset asserted mid-run after 2 beats -> all outputs 0 same edge; rerun full pass case -> o_pass=1.

Source files
------------

// File: rtl/status_pkg.sv
// Shared status codes, terminal test and checker FSM state type.
package status_pkg;

  localparam logic [1:0] R_TYPE        = 2'd0;
  localparam logic [1:0] I_TYPE        = 2'd1;
  localparam logic [1:0] MIPS_OVERFLOW = 2'd2;
  localparam logic [1:0] MIPS_END      = 2'd3;

  typedef enum logic {S_RUN = 1'b0, S_DONE = 1'b1} state_e;

  function automatic logic is_terminal(input logic [1:0] s);
    return (s == MIPS_OVERFLOW) || (s == MIPS_END);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         gclk,
  input  logic         grst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)                       cnt <= '0;
    else if (clr)                      cnt <= '0;
    else if (inc && (cnt != {W{1'b1}})) cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/status_checker.sv
// Compares core status beats against a golden ROM and declares pass/fail on a terminal beat.
// Optional idle watchdog enabled by defining STATUS_WDOG_EN.
module status_checker
  import status_pkg::*;
#(
  parameter int GOLD_AW  = 8,
  parameter int CNT_W    = 16,
  parameter int WDOG_CYC = 120000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [1:0]         i_status,
  input  logic               i_status_valid,
  output logic [GOLD_AW-1:0] o_g_addr,
  input  logic [1:0]         i_g_status,
  output logic               o_done,
  output logic               o_pass,
  output logic [CNT_W-1:0]   o_err_cnt,
  output logic [CNT_W-1:0]   o_beat_cnt,
  output logic [GOLD_AW-1:0] o_first_err,
  output logic               o_proto_err
);

  state_e state;
  logic   accept, term, at_max, mism, ovf, wdog_hit, finish, late_beat;

  assign accept    = (state == S_RUN) && i_status_valid;
  assign term      = is_terminal(i_status) || is_terminal(i_g_status);
  assign at_max    = &o_g_addr;
  assign mism      = accept && (i_status != i_g_status);
  assign ovf       = accept && !term && at_max;
  assign late_beat = (state == S_DONE) && i_status_valid;
  assign finish    = (accept && (term || at_max)) || wdog_hit;

`ifdef STATUS_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYC + 1);
  logic [WD_W-1:0] wdog_cnt;
  logic            wdog_inc;

  assign wdog_inc = (state == S_RUN);
  // Hit on the WDOG_CYC-th consecutive idle cycle in RUN.
  assign wdog_hit = (state == S_RUN) && !accept && (wdog_cnt == WD_W'(WDOG_CYC - 1));

  sat_counter #(.W(WD_W)) u_wdog (
    .gclk(i_clk), .grst_n(i_rst_n), .clr(accept), .inc(wdog_inc), .cnt(wdog_cnt)
  );
`else
  assign wdog_hit = 1'b0;
`endif

  sat_counter #(.W(CNT_W)) u_beat (
    .gclk(i_clk), .grst_n(i_rst_n), .clr(1'b0), .inc(accept), .cnt(o_beat_cnt)
  );

  sat_counter #(.W(CNT_W)) u_err (
    .gclk(i_clk), .grst_n(i_rst_n), .clr(1'b0), .inc(mism), .cnt(o_err_cnt)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_RUN;
      o_g_addr    <= '0;
      o_first_err <= '0;
      o_proto_err <= 1'b0;
    end else begin
      if (finish) state <= S_DONE;
      // Address holds at the top index rather than wrapping.
      if (accept && !at_max) o_g_addr <= o_g_addr + GOLD_AW'(1);
      // Saturating error count never returns to zero, so zero marks "no mismatch yet".
      if (mism && (o_err_cnt == '0)) o_first_err <= o_g_addr;
      if (ovf || wdog_hit || late_beat) o_proto_err <= 1'b1;
    end
  end

  assign o_done = (state == S_DONE);
  assign o_pass = o_done && (o_err_cnt == '0) && !o_proto_err;

endmodule

// File: tb/tb_status_checker.sv
// Scoreboard bench: driver pushes model-predicted final results, monitor checks on o_done rise.
module tb_status_checker;

  localparam int GAW = 3;
  localparam int N   = 2 ** GAW;
  localparam int CW  = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [1:0]     status;
  logic           status_valid;
  logic [GAW-1:0] g_addr;
  logic [1:0]     g_status;
  logic           done, pass, proto_err;
  logic [CW-1:0]  err_cnt, beat_cnt;
  logic [GAW-1:0] first_err;

  logic [1:0] gold [N];
  logic [1:0] seq  [N];

  typedef struct {
    int pass; int err; int beat; int first; int proto; int addr; int cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign g_status = gold[g_addr];

  status_checker #(.GOLD_AW(GAW), .CNT_W(CW), .WDOG_CYC(120000)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_status(status), .i_status_valid(status_valid),
    .o_g_addr(g_addr), .i_g_status(g_status), .o_done(done), .o_pass(pass),
    .o_err_cnt(err_cnt), .o_beat_cnt(beat_cnt), .o_first_err(first_err),
    .o_proto_err(proto_err)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: walk beats in order, stop at first terminal code or at the last ROM index.
  function automatic exp_t model(output int nb);
    exp_t e;
    e = '{pass: 0, err: 0, beat: 0, first: 0, proto: 0, addr: 0, cyc: 0};
    nb = 0;
    for (int i = 0; i < N; i++) begin
      nb = i + 1;
      e.beat++;
      if (seq[i] != gold[i]) begin
        if (e.err == 0) e.first = i;
        e.err++;
      end
      if (seq[i] >= 2 || gold[i] >= 2) begin
        e.addr = (i == N - 1) ? i : i + 1;
        e.pass = (e.err == 0) ? 1 : 0;
        return e;
      end
      if (i == N - 1) begin
        e.proto = 1;
        e.addr  = i;
        return e;
      end
    end
    return e;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_err"}, int'(err_cnt), 0);
    chk({tag, "_beat"}, int'(beat_cnt), 0);
    chk({tag, "_first"}, int'(first_err), 0);
    chk({tag, "_proto"}, proto_err, 0);
    chk({tag, "_addr"}, int'(g_addr), 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_case(input bit b2b);
    exp_t e;
    int   nb;
    e = model(nb);
    for (int i = 0; i < nb; i++) begin
      if (!b2b && i > 0) repeat ($urandom_range(0, 2)) @(negedge clk);
      status       = seq[i];
      status_valid = 1'b1;
      if (i == nb - 1) begin
        e.cyc = cyc + 1;
        q.push_back(e);
      end
      @(negedge clk);
      status_valid = 1'b0;
    end
    for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL done_timeout pending=%0d expected=0", q.size());
      q.delete();
    end
  endtask

  task automatic set4(input logic [1:0] g0, g1, g2, g3, input logic [1:0] d0, d1, d2, d3);
    for (int i = 0; i < N; i++) begin gold[i] = 2'd0; seq[i] = 2'd0; end
    gold[0] = g0; gold[1] = g1; gold[2] = g2; gold[3] = g3;
    seq[0]  = d0; seq[1]  = d1; seq[2]  = d2; seq[3]  = d3;
  endtask

  // Monitor: the output event is the rising edge of o_done.
  initial begin
    logic done_q;
    exp_t e;
    done_q = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && done && !done_q) begin
        if (q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_done actual=1 expected=0 (t=%0t)", $time);
        end else begin
          e = q.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("pass", pass, e.pass);
          chk("err_cnt", int'(err_cnt), e.err);
          chk("beat_cnt", int'(beat_cnt), e.beat);
          chk("first_err", int'(first_err), e.first);
          chk("proto_err", proto_err, e.proto);
          chk("g_addr", int'(g_addr), e.addr);
        end
      end
      done_q = done;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n        = 1'b0;
    status       = 2'd0;
    status_valid = 1'b0;
    for (int i = 0; i < N; i++) begin gold[i] = 2'd0; seq[i] = 2'd0; end
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    // Clean pass, back-to-back beats
    set4(0, 1, 0, 3, 0, 1, 0, 3);
    run_case(1'b1);

    // Beat after done: protocol error, counters frozen
    @(negedge clk);
    status = 2'd1; status_valid = 1'b1;
    @(negedge clk);
    status_valid = 1'b0;
    chk("late_proto", proto_err, 1);
    chk("late_pass", pass, 0);
    chk("late_done", done, 1);
    chk("late_beat", int'(beat_cnt), 4);
    chk("late_err", int'(err_cnt), 0);
    chk("late_addr", int'(g_addr), 4);

    do_reset("rst_b");
    set4(0, 1, 3, 0, 0, 0, 3, 0);
    run_case(1'b0);

    do_reset("rst_c");
    set4(0, 0, 0, 3, 0, 2, 0, 0);
    run_case(1'b0);

    // Index overflow with no terminal code
    do_reset("rst_e");
    for (int i = 0; i < N; i++) begin gold[i] = 2'd0; seq[i] = 2'd0; end
    run_case(1'b1);
    @(negedge clk);
    chk("ovf_addr_hold", int'(g_addr), N - 1);

    // Reset mid-run, then full rerun
    do_reset("rst_f");
    set4(0, 1, 0, 3, 0, 1, 0, 3);
    for (int i = 0; i < 2; i++) begin
      status = seq[i]; status_valid = 1'b1;
      @(negedge clk);
    end
    status_valid = 1'b0;
    chk("mid_beat", int'(beat_cnt), 2);
    do_reset("rst_mid");
    run_case(1'b1);

    for (int t = 0; t < 40; t++) begin
      do_reset("rst_rand");
      for (int i = 0; i < N; i++) begin
        int r;
        r = $urandom_range(0, 9);
        gold[i] = (r == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
        seq[i]  = ($urandom_range(0, 99) < 15) ? 2'($urandom_range(0, 3)) : gold[i];
      end
      run_case(1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
